ps2_mouse_rx: RTL and testbench

- Receives the raw PS/2 mouse serial stream (device-clocked, 11-bit frames) and assembles standard 3-byte movement packets.
- Publishes each packet as the 25-bit toggle-strobed `ps2_mouse` word consumed by the paddle controllers (mouse-as-paddle path).
- It is the producing end of the `ps2_mouse` interface. It sits between the PS/2 pins (or the HPS PS/2 bridge) and the paddle logic, in the `clk_sys` domain.

---
 rtl/ps2_mouse_rx.sv | 278 +++++++++++++++++++++++++++
 tb/tb_ps2_mouse_rx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_rx.sv
// ---------------------------------------------------------------------------
// ps2_mouse_rx
//
// Receives the raw PS/2 mouse serial stream (device-clocked 11-bit frames:
// start, 8 data bits LSB first, odd parity, stop) and assembles standard
// 3-byte movement packets. Each completed packet is published on the 25-bit
// toggle-strobed ps2_mouse word; bit 24 flips once per packet so a consumer
// in the clk domain detects new data by watching that bit.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   ps2_clk_in   PS/2 clock line, asynchronous, idle high
//   ps2_data_in  PS/2 data line, asynchronous, idle high
//   ps2_mouse    {toggle, byte2 (dY), byte1 (dX), byte0 (status)}
//   frame_err    one-cycle pulse on any discarded byte or packet
//   busy         high while a frame is in progress (frame FSM not IDLE)
//
// Handshake: ps2_mouse has no valid/ready pair. It is a level that holds
// between packets; a change of bit 24 marks a new packet, and all 25 bits
// change in the same clk cycle so the word is always coherent.
// ---------------------------------------------------------------------------
module ps2_mouse_rx #(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [24:0] ps2_mouse,
  output logic        frame_err,
  output logic        busy
);

  // Counter widths: the filter counter reaches FILT_LEN-1, the timeout
  // counter reaches TIMEOUT-1.
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  // Frame FSM encoding.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // -------------------------------------------------------------------------
  // Input conditioning: 2-FF synchroniser followed by a glitch filter on
  // each line. A filtered level flips only after FILT_LEN consecutive
  // synchronised samples disagree with it; any agreeing sample restarts
  // the count, so pulses shorter than FILT_LEN cycles are ignored.
  // -------------------------------------------------------------------------
  logic [1:0]    clk_sync_q, data_sync_q;
  logic [FW-1:0] clk_cnt_q, clk_cnt_d;
  logic [FW-1:0] data_cnt_q, data_cnt_d;
  logic          clk_filt_q, clk_filt_d;
  logic          data_filt_q, data_filt_d;
  logic          clk_prev_q;

  always_comb begin
    clk_filt_d = clk_filt_q;
    clk_cnt_d  = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (clk_cnt_q == FW'(FILT_LEN - 1)) begin
        clk_filt_d = clk_sync_q[1];
      end else begin
        clk_cnt_d = clk_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    data_filt_d = data_filt_q;
    data_cnt_d  = '0;
    if (data_sync_q[1] != data_filt_q) begin
      if (data_cnt_q == FW'(FILT_LEN - 1)) begin
        data_filt_d = data_sync_q[1];
      end else begin
        data_cnt_d = data_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_cnt_q   <= '0;
      data_cnt_q  <= '0;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_cnt_q   <= clk_cnt_d;
      data_cnt_q  <= data_cnt_d;
      clk_filt_q  <= clk_filt_d;
      data_filt_q <= data_filt_d;
      clk_prev_q  <= clk_filt_q;
    end
  end

  // Filtered falling edge of ps2_clk; the filtered data level is the bit
  // sampled by this edge.
  logic fall;
  logic sample;
  assign fall   = clk_prev_q & ~clk_filt_q;
  assign sample = data_filt_q;

  // -------------------------------------------------------------------------
  // Timeout: counts while a frame or a partial packet is pending and clears
  // on every falling edge. An edge in the same cycle as expiry wins, since
  // the expiry test sits in the no-edge branch.
  // -------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout;
  logic          counting;

  assign counting = (state_q != S_IDLE) || (idx_q != 2'd0);

  always_comb begin
    to_cnt_d = to_cnt_q;
    timeout  = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
    end else if (counting) begin
      if (to_cnt_q == TW'(TIMEOUT - 1)) begin
        timeout  = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM. Produces a one-cycle byte_vld or byte_err pulse after the
  // stop bit, with the received byte held in byte_q.
  // -------------------------------------------------------------------------
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       parity_q, parity_d;
  logic       byte_vld_q, byte_vld_d;
  logic       byte_err_q, byte_err_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    byte_err_d = 1'b0;
    if (fall) begin
      case (state_q)
        S_IDLE: begin
          // A high level on the falling edge is not a start bit; ignore it.
          if (!sample) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d = {sample, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_PARITY: begin
          parity_d = sample;
          state_d  = S_STOP;
        end
        default: begin
          // Odd parity across the 8 data bits plus the parity bit.
          byte_d = shift_q;
          if (sample && ((^shift_q) ^ parity_q)) begin
            byte_vld_d = 1'b1;
          end else begin
            byte_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      endcase
    end else if (timeout) begin
      state_d = S_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Packet assembly. byte0 must have bit 3 set; a byte at index 0 without
  // it is treated as a misaligned stream and dropped so the receiver can
  // resynchronise on the next real status byte.
  // -------------------------------------------------------------------------
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic [24:0] mouse_q, mouse_d;
  logic        err_q, err_d;

  always_comb begin
    idx_d   = idx_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    mouse_d = mouse_q;
    err_d   = 1'b0;
    if (byte_err_q) begin
      idx_d = 2'd0;
      err_d = 1'b1;
    end else if (byte_vld_q) begin
      case (idx_q)
        2'd0: begin
          if (!byte_q[3]) begin
            err_d = 1'b1;
          end else begin
            b0_d  = byte_q;
            idx_d = 2'd1;
          end
        end
        2'd1: begin
          b1_d  = byte_q;
          idx_d = 2'd2;
        end
        default: begin
          mouse_d = {~mouse_q[24], byte_q, b1_q, b0_q};
          idx_d   = 2'd0;
        end
      endcase
    end
    if (timeout) begin
      idx_d = 2'd0;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      byte_q     <= 8'd0;
      parity_q   <= 1'b0;
      byte_vld_q <= 1'b0;
      byte_err_q <= 1'b0;
      to_cnt_q   <= '0;
      idx_q      <= 2'd0;
      b0_q       <= 8'd0;
      b1_q       <= 8'd0;
      mouse_q    <= 25'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      parity_q   <= parity_d;
      byte_vld_q <= byte_vld_d;
      byte_err_q <= byte_err_d;
      to_cnt_q   <= to_cnt_d;
      idx_q      <= idx_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      mouse_q    <= mouse_d;
      err_q      <= err_d;
    end
  end

  assign ps2_mouse = mouse_q;
  assign frame_err = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// ---------------------------------------------------------------------------
// Testbench for ps2_mouse_rx: drives PS/2 frames from tasks, pushes the
// expected packet word to exp_q when a packet is sent and pops/compares it
// when bit 24 of ps2_mouse toggles.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_rx;

  localparam int FILT_LEN = 8;
  localparam int TIMEOUT  = 2000;
  localparam int HALF     = 30;   // PS/2 half period in clk cycles
  localparam int GAP      = 20;   // idle cycles between frames

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [24:0] ps2_mouse;
  logic        frame_err;
  logic        busy;

  always #5 clk = ~clk;

  ps2_mouse_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_mouse  (ps2_mouse),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // ---------------- scoreboard state ----------------
  logic [24:0] exp_q[$];
  logic [24:0] model_word = 25'd0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          err_cnt = 0;

  always @(negedge clk) begin
    if (!reset && frame_err) err_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data_in = b;
    repeat (4) @(negedge clk);
    if (glitch) begin
      ps2_clk_in = 1'b0;
      repeat (FILT_LEN - 2) @(negedge clk);
      ps2_clk_in = 1'b1;
    end
    repeat (HALF - 4 - (glitch ? FILT_LEN - 2 : 0)) @(negedge clk);
    ps2_clk_in = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 2));
    send_bit(p, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data_in = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  // Pushes the expected word, then drives the three frames.
  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input bit glitch);
    logic tog;
    tog = (exp_q.size() > 0) ? ~exp_q[$][24] : ~model_word[24];
    exp_q.push_back({tog, b2, b1, b0});
    send_frame(b0, 1'b0, glitch);
    send_frame(b1, 1'b0, glitch);
    send_frame(b2, 1'b0, glitch);
  endtask

  // Waits (bounded) for bit 24 to move away from the last modelled value.
  task automatic wait_pkt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (ps2_mouse[24] !== model_word[24]) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1;
    n_cmp++;
    if (ps2_mouse !== 25'd0) begin
      n_fail++; $display("FAIL reset_mouse: got %h expected %h", ps2_mouse, 25'd0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err);
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    int e0;
    e0 = err_cnt;
    for (int k = 0; k < 2; k++) begin
      send_packet(8'h09, 8'h05, 8'hFB, 1'b0);
      wait_pkt(ok);
      n_cmp++;
      if (!ok || ps2_mouse !== exp_q[0]) begin
        n_fail++; $display("FAIL basic_pkt%0d: got %h expected %h", k, ps2_mouse, exp_q[0]);
      end
      model_word = exp_q.pop_front();
    end
    n_cmp++;
    if (model_word !== 25'h0FB0509 || ps2_mouse !== 25'h0FB0509) begin
      n_fail++; $display("FAIL basic_second: got %h expected %h", ps2_mouse, 25'h0FB0509);
    end
    n_cmp++;
    if (err_cnt - e0 != 0) begin
      n_fail++; $display("FAIL basic_err: got %0d expected 0", err_cnt - e0);
    end
  endtask

  task automatic test_parity_error;
    bit ok;
    int e0;
    e0 = err_cnt;
    send_frame(8'h09, 1'b0, 1'b0);
    send_frame(8'h05, 1'b1, 1'b0);
    n_cmp++;
    if (err_cnt - e0 != 1) begin
      n_fail++; $display("FAIL parity_err: got %0d expected 1", err_cnt - e0);
    end
    n_cmp++;
    if (ps2_mouse !== model_word) begin
      n_fail++; $display("FAIL parity_hold: got %h expected %h", ps2_mouse, model_word);
    end
    send_packet(8'h0A, 8'h00, 8'h10, 1'b0);
    wait_pkt(ok);
    n_cmp++;
    if (!ok || ps2_mouse !== exp_q[0]) begin
      n_fail++; $display("FAIL parity_next: got %h expected %h", ps2_mouse, exp_q[0]);
    end
    model_word = exp_q.pop_front();
  endtask

  task automatic test_resync;
    bit ok;
    int e0;
    e0 = err_cnt;
    send_frame(8'h05, 1'b0, 1'b0);
    send_packet(8'h08, 8'h7F, 8'h80, 1'b0);
    wait_pkt(ok);
    n_cmp++;
    if (!ok || ps2_mouse !== exp_q[0]) begin
      n_fail++; $display("FAIL resync_pkt: got %h expected %h", ps2_mouse, exp_q[0]);
    end
    model_word = exp_q.pop_front();
    n_cmp++;
    if (err_cnt - e0 != 1) begin
      n_fail++; $display("FAIL resync_err: got %0d expected 1", err_cnt - e0);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int e0;
    e0 = err_cnt;
    repeat (TIMEOUT + 10) @(negedge clk);
    n_cmp++;
    if (err_cnt - e0 != 0) begin
      n_fail++; $display("FAIL idle_no_timeout: got %0d expected 0", err_cnt - e0);
    end
    send_frame(8'h08, 1'b0, 1'b0);
    repeat (TIMEOUT + 10) @(negedge clk);
    n_cmp++;
    if (err_cnt - e0 != 1) begin
      n_fail++; $display("FAIL timeout_err: got %0d expected 1", err_cnt - e0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_busy: got %b expected 0", busy);
    end
    send_packet(8'h09, 8'h01, 8'h02, 1'b0);
    wait_pkt(ok);
    n_cmp++;
    if (!ok || ps2_mouse !== exp_q[0]) begin
      n_fail++; $display("FAIL timeout_next: got %h expected %h", ps2_mouse, exp_q[0]);
    end
    model_word = exp_q.pop_front();
  endtask

  task automatic test_glitch;
    bit ok;
    int e0;
    e0 = err_cnt;
    ps2_clk_in = 1'b0;
    repeat (FILT_LEN - 2) @(negedge clk);
    ps2_clk_in = 1'b1;
    repeat (GAP) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL glitch_idle_busy: got %b expected 0", busy);
    end
    send_packet(8'h09, 8'h05, 8'hFB, 1'b1);
    wait_pkt(ok);
    n_cmp++;
    if (!ok || ps2_mouse !== exp_q[0]) begin
      n_fail++; $display("FAIL glitch_pkt: got %h expected %h", ps2_mouse, exp_q[0]);
    end
    model_word = exp_q.pop_front();
    n_cmp++;
    if (err_cnt - e0 != 0) begin
      n_fail++; $display("FAIL glitch_err: got %0d expected 0", err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int e0;
    logic [7:0] b1;
    b1 = 8'h05;
    send_frame(8'h09, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(b1[i], 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL midframe_busy: got %b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ps2_mouse !== 25'd0) begin
      n_fail++; $display("FAIL midreset_mouse: got %h expected %h", ps2_mouse, 25'd0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy);
    end
    model_word = 25'd0;
    ps2_clk_in  = 1'b1;
    ps2_data_in = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (GAP) @(negedge clk);
    e0 = err_cnt;
    send_packet(8'h09, 8'h05, 8'hFB, 1'b0);
    wait_pkt(ok);
    n_cmp++;
    if (!ok || ps2_mouse !== 25'h1FB0509 || exp_q[0] !== 25'h1FB0509) begin
      n_fail++; $display("FAIL postreset_pkt: got %h expected %h", ps2_mouse, 25'h1FB0509);
    end
    model_word = exp_q.pop_front();
    n_cmp++;
    if (err_cnt - e0 != 0) begin
      n_fail++; $display("FAIL postreset_err: got %0d expected 0", err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [7:0] b0, b1, b2;
    for (int k = 0; k < 4; k++) begin
      b0 = 8'($urandom_range(0, 255)) | 8'h08;
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      send_packet(b0, b1, b2, 1'b0);
      wait_pkt(ok);
      n_cmp++;
      if (!ok || ps2_mouse !== exp_q[0]) begin
        n_fail++; $display("FAIL b2b_pkt%0d: got %h expected %h", k, ps2_mouse, exp_q[0]);
      end
      model_word = exp_q.pop_front();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_resync();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
